// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares the single write port of a byte
//            FIFO among NUM_REQ valid/ready producer streams. One producer is
//            granted at a time. Beats are accepted only while the FIFO has
//            room. The FIFO write strobe and data are driven from registers.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            req_valid    - per-producer beat valid            [NUM_REQ]
//            req_data     - producer i beat at [i*DATA_W +: DATA_W]
//            req_ready    - per-producer accept (combinational, one-hot/zero)
//            fifo_count   - FIFO occupancy                     [CNT_W]
//            fifo_wr_en   - registered FIFO write strobe
//            fifo_wr_data - registered FIFO write data         [DATA_W]
//            grant_id     - current / most recent grantee index
//            busy         - high while a grant is active
// Options  : FIFO_ARB_BURST_EN - when defined, a grant may carry up to
//            BURST_LEN consecutive beats. Otherwise every grant carries
//            exactly one beat.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]            fifo_count,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Elaboration-time sanity check of the parameter set.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BURST_LEN < 1) || (BURST_LEN > 15) ||
      (DEPTH < 1) || (DEPTH > ((1 << CNT_W) - 1)) || (DATA_W < 1)) begin : g_param_check
    $error("fifo_wr_arbiter: unsupported parameter combination");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;

  logic               space_ok;
  logic               grant_valid;
  logic [DATA_W-1:0]  grant_data;
  logic               xfer;
  logic               last_beat;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  int                 cand;

  // One extra bit so that count + in-flight write cannot wrap. The in-flight
  // term covers a beat already on fifo_wr_en but not yet in fifo_count.
  assign space_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr_en})
                    < (CNT_W+1)'(DEPTH);

  assign grant_valid = req_valid[grant_id];
  assign grant_data  = req_data[grant_id*DATA_W +: DATA_W];
  assign xfer        = (state == ST_GRANT) && grant_valid && space_ok;
  assign busy        = (state == ST_GRANT);

  // Only the grantee can be ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (state == ST_GRANT) begin
      req_ready[grant_id] = space_ok;
    end
  end

  // Round-robin search. It starts one past the last grantee and wraps, so the
  // previous winner has the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(cand);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] beat_cnt;

  // This is the last beat of the burst when beat_cnt already holds
  // BURST_LEN-1 beats.
  assign last_beat = (beat_cnt == 4'(BURST_LEN - 1));
`else
  // Single-beat grants: every transfer ends the grant.
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt     <= '0;
`endif
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            state    <= ST_GRANT;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!grant_valid) begin
            // The grantee has nothing more to send, so give up the port.
            state  <= ST_IDLE;
            rr_ptr <= grant_id;
          end else if (xfer) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= grant_data;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt     <= beat_cnt + 4'd1;
`endif
            if (last_beat) begin
              state  <= ST_IDLE;
              rr_ptr <= grant_id;
            end
          end
          // The FIFO is full here: hold the grant with no timeout.
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter. A transaction-level
//            model inside the bench predicts grants, ready and FIFO writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int CW    = 8;
  localparam int BL    = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int LIMIT = BL;
`else
  localparam int LIMIT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   fifo_count = '0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_count(fifo_count), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the port, how many beats it has sent, who had
  // the port last, and what the FIFO write port shows after the last edge.
  bit          m_busy;
  int          m_gid;
  int          m_ptr;
  int          m_beats;
  bit          m_wr;
  logic [7:0]  m_data;
  bit          drain;       // FIFO consumer pops one entry this cycle
  logic [N-1:0] acc;        // beats the model says were accepted at last edge

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = N - 1; m_beats = 0; m_wr = 0; m_data = '0;
    acc = '0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_busy && (int'(fifo_count) + int'(m_wr)) < DEPTH) r[m_gid] = 1'b1;
    return r;
  endfunction

  // Advance one clock: apply the spec rules to the inputs held before the edge.
  // The FIFO occupancy is also updated here.
  task automatic tick();
    logic [N-1:0]    r, v;
    logic [N*DW-1:0] d;
    int nc, c;
    r = exp_ready(); v = req_valid; d = req_data;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      acc = r & v;
      nc = int'(fifo_count) + int'(m_wr);
      if (drain && nc > 0) nc--;
      fifo_count = CW'(nc);
      if (!m_busy) begin
        m_wr = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (v[c]) begin
            m_gid = c; m_busy = 1; m_beats = 0;
            break;
          end
        end
      end else if (!v[m_gid]) begin
        m_busy = 0; m_ptr = m_gid; m_wr = 0;
      end else if (r[m_gid]) begin
        m_wr = 1; m_data = d[m_gid*DW +: DW]; m_beats++;
        if (m_beats == LIMIT) begin m_busy = 0; m_ptr = m_gid; end
      end else begin
        m_wr = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_count = '0; drain = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    int order[$];
    bit pb;
    #2 rst = 1'b1;
    model_reset(); fifo_count = '0; drain = 1;
    #1;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++; if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1 rst = 1'b0;
    req_valid = 4'b0101;
    req_data  = {$urandom, $urandom} & {N*DW{1'b1}};
    pb = 0;
    for (int c = 0; c < 30 && order.size() < 2; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL reset_seq_ready: got %b want %b", req_ready, exp_ready()); end
      tick();
      n_checks++; if (fifo_wr_en !== m_wr) begin n_fail++; $display("FAIL reset_seq_wr_en: got %b want %b", fifo_wr_en, m_wr); end
      if (busy && !pb) order.push_back(int'(grant_id));
      pb = busy;
      for (int i = 0; i < N; i++) if (acc[i]) req_valid[i] = 1'b0;
    end
    n_checks++;
    if (order.size() < 2) begin
      n_fail++; $display("FAIL reset_order_timeout: got %0d grants want 2", order.size());
    end else begin
      if (order[0] != 0 || order[1] != 2) begin
        n_fail++; $display("FAIL reset_order: got %0d,%0d want 0,2", order[0], order[1]);
      end
    end
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fairness();
    int order[$], beats[$], idles[$];
    int cur, idle;
    int want_order[5] = '{0, 1, 2, 3, 0};
    bit pb;
    do_reset();
    drain = 1; req_valid = '1;
    req_data = {$urandom, $urandom} & {N*DW{1'b1}};
    cur = 0; idle = 0; pb = 0;
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL fair_ready: got %b want %b", req_ready, exp_ready()); end
      if (busy) cur += $countones(req_ready & req_valid);
      tick();
      n_checks++; if (fifo_wr_en !== m_wr || fifo_wr_data !== m_data) begin n_fail++; $display("FAIL fair_write: got %b/%h want %b/%h", fifo_wr_en, fifo_wr_data, m_wr, m_data); end
      if (busy && !pb) begin
        order.push_back(int'(grant_id));
        if (order.size() > 1) begin beats.push_back(cur); idles.push_back(idle); end
        cur = 0; idle = 0;
      end
      if (!busy) idle++;
      pb = busy;
      for (int i = 0; i < N; i++) if (acc[i]) req_data[i*DW +: DW] = DW'($urandom);
    end
    n_checks++;
    if (order.size() < 5) begin
      n_fail++; $display("FAIL fair_timeout: got %0d grants want 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) if (order[k] != want_order[k]) begin
        n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, order[k], want_order[k]);
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (beats[k] != LIMIT) begin n_fail++; $display("FAIL fair_beats[%0d]: got %0d want %0d", k, beats[k], LIMIT); end
        n_checks++; if (idles[k] != 1) begin n_fail++; $display("FAIL fair_idle[%0d]: got %0d want 1", k, idles[k]); end
      end
    end
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_stall();
    bit got;
    do_reset();
    drain = 0; fifo_count = CW'(63);
    req_valid = 4'b0010; req_data[15:8] = 8'h5A;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL stall_ready: got %b want %b", req_ready, exp_ready()); end
      tick();
      got = acc[1];
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL stall_accept_timeout: got none want 1 accept"); end
    req_data[15:8] = 8'hC3;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready_drop: got %b want 0000", req_ready); end
    repeat (2) begin
      tick(); #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL stall_settle_ready: got %b want %b", req_ready, exp_ready()); end
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_hold_ready: got %b want 0000", req_ready); end
      tick();
      n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_hold_wr_en: got %b want 0", fifo_wr_en); end
      n_checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL stall_hold_grant: got busy %b id %0d want 1/1", busy, grant_id); end
      #1;
    end
    fifo_count = CW'(63);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_ready_return: got %b want 0010", req_ready); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hC3) begin n_fail++; $display("FAIL stall_resume_write: got %b/%h want 1/c3", fifo_wr_en, fifo_wr_data); end
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_early_release();
    int order[$];
    int n2, b2, idle, idle_between;
    bit pb;
    do_reset();
    drain = 1; req_valid = 4'b1100;
    req_data = {$urandom, $urandom} & {N*DW{1'b1}};
    n2 = 0; b2 = -1; idle = 0; idle_between = -1; pb = 0;
    for (int c = 0; c < 40 && order.size() < 2; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL early_ready: got %b want %b", req_ready, exp_ready()); end
      tick();
      n_checks++; if (fifo_wr_en !== m_wr || fifo_wr_data !== m_data) begin n_fail++; $display("FAIL early_write: got %b/%h want %b/%h", fifo_wr_en, fifo_wr_data, m_wr, m_data); end
      if (busy && !pb) begin
        order.push_back(int'(grant_id));
        if (order.size() == 2) begin b2 = n2; idle_between = idle; end
        idle = 0;
      end
      if (!busy) idle++;
      pb = busy;
      if (acc[2]) begin
        n2++;
        if (n2 >= 2) req_valid[2] = 1'b0; else req_data[23:16] = DW'($urandom);
      end
      if (acc[3]) req_valid[3] = 1'b0;
    end
    n_checks++;
    if (order.size() < 2) begin
      n_fail++; $display("FAIL early_timeout: got %0d grants want 2", order.size());
    end else begin
      if (order[0] != 2 || order[1] != 3) begin n_fail++; $display("FAIL early_order: got %0d,%0d want 2,3", order[0], order[1]); end
      n_checks++; if (b2 != ((LIMIT >= 2) ? 2 : 1)) begin n_fail++; $display("FAIL early_beats: got %0d want %0d", b2, (LIMIT >= 2) ? 2 : 1); end
      n_checks++; if (idle_between != 1) begin n_fail++; $display("FAIL early_idle: got %0d want 1", idle_between); end
    end
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_data_path();
    int acc_cyc[$], wr_cyc[$];
    logic [7:0] wr_val[$];
    int sent;
    do_reset();
    drain = 1; req_valid = 4'b0010; req_data[15:8] = 8'hA5;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      tick();
      if (acc[1]) begin
        acc_cyc.push_back(c);
        sent++;
        if (sent == 1) req_data[15:8] = 8'h3C; else req_valid[1] = 1'b0;
      end
      if (fifo_wr_en === 1'b1) begin wr_cyc.push_back(c + 1); wr_val.push_back(fifo_wr_data); end
    end
    n_checks++;
    if (wr_val.size() != 2 || acc_cyc.size() != 2) begin
      n_fail++; $display("FAIL data_count: got %0d writes want 2", wr_val.size());
    end else begin
      n_checks++; if (wr_val[0] !== 8'hA5) begin n_fail++; $display("FAIL data_beat0: got %h want a5", wr_val[0]); end
      n_checks++; if (wr_val[1] !== 8'h3C) begin n_fail++; $display("FAIL data_beat1: got %h want 3c", wr_val[1]); end
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (wr_cyc[k] != acc_cyc[k] + 1) begin n_fail++; $display("FAIL data_latency[%0d]: got %0d want 1", k, wr_cyc[k] - acc_cyc[k]); end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_reset();
    int order[$], beats[$];
    int cur;
    bit got, pb;
    do_reset();
    drain = 1; req_valid = '1;
    req_data = {$urandom, $urandom} & {N*DW{1'b1}};
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1; tick();
      got = (fifo_wr_en === 1'b1);
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL midrst_wr_timeout: got none want a write"); end
    #2 rst = 1'b1;
    model_reset(); fifo_count = '0;
    #1;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_idle: got busy %b ready %b want 0/0000", busy, req_ready); end
    @(posedge clk); #1 rst = 1'b0;
    cur = 0; pb = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL midrst_ready: got %b want %b", req_ready, exp_ready()); end
      if (busy) cur += $countones(req_ready & req_valid);
      tick();
      if (busy && !pb) begin
        order.push_back(int'(grant_id));
        if (order.size() > 1) beats.push_back(cur);
        cur = 0;
      end
      pb = busy;
    end
    n_checks++;
    if (order.size() < 4) begin
      n_fail++; $display("FAIL midrst_timeout: got %0d grants want 4", order.size());
    end else begin
      if (order[0] != 0) begin n_fail++; $display("FAIL midrst_first: got %0d want 0", order[0]); end
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (beats[k] != LIMIT) begin n_fail++; $display("FAIL midrst_beats[%0d]: got %0d want %0d", k, beats[k], LIMIT); end
      end
    end
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    int pct;
    do_reset();
    fifo_count = CW'($urandom_range(40, 63));
    pct = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) pct = $urandom_range(10, 95);
      drain = ($urandom_range(0, 99) < pct);
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready @%0d: got %b want %b", c, req_ready, exp_ready()); end
      tick();
      n_checks++; if (fifo_wr_en !== m_wr) begin n_fail++; $display("FAIL rand_wr_en @%0d: got %b want %b", c, fifo_wr_en, m_wr); end
      n_checks++; if (fifo_wr_data !== m_data) begin n_fail++; $display("FAIL rand_wr_data @%0d: got %h want %h", c, fifo_wr_data, m_data); end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy @%0d: got %b want %b", c, busy, m_busy); end
      n_checks++; if (int'(grant_id) != m_gid) begin n_fail++; $display("FAIL rand_grant_id @%0d: got %0d want %0d", c, grant_id, m_gid); end
      // Producers hold valid/data until accepted, then choose freely.
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_data[i*DW +: DW] = DW'($urandom);
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    drain = 0;
    test_reset();
    test_fairness();
    test_full_stall();
    test_early_release();
    test_data_path();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single-clock byte FIFO's one write port among NUM_REQ producer streams. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time, gates acceptance on FIFO free space, and drives the FIFO's `wr_en`/`buf_in` from registered outputs. It sits directly in front of the FIFO, and its `fifo_count` input comes from the FIFO's occupancy counter.

## Interface
Parameters:
- NUM_REQ, 4: number of producers, 2..8.
- DATA_W, 8: beat width; must equal the FIFO data width.
- DEPTH, 64: FIFO capacity in entries.
- CNT_W, 8: width of `fifo_count`; must hold DEPTH.
- BURST_LEN, 4: maximum beats per grant, 1..15 (used only with burst mode).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_data  in  NUM_REQ*DATA_W  producer i's beat in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-producer accept; combinational; one-hot or zero.
- fifo_count  in  CNT_W  FIFO occupancy.
- fifo_wr_en  out  1  registered FIFO write strobe.
- fifo_wr_data  out  DATA_W  registered FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee.
- busy  out  1  high while in GRANT.

## Operation
- States are IDLE and GRANT. `rr_ptr` holds the last granted index.
- **IDLE:** if any `req_valid` is set, select the first requester at or after `rr_ptr+1` (mod NUM_REQ) with valid high. Load `grant_id`, clear `beat_cnt`, go to GRANT. No beat is accepted in IDLE, so all `req_ready` are 0.
- **GRANT:**
  - `space_ok` = (`fifo_count` + `fifo_wr_en`) < DEPTH. The `fifo_wr_en` term accounts for a beat that is in flight but not yet counted.
  - `req_ready[grant_id]` = `space_ok`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[grant_id]` and `req_ready[grant_id]` are both high. On a transfer: `fifo_wr_data` <= beat, `fifo_wr_en` <= 1, `beat_cnt`++.
  - With no transfer, `fifo_wr_en` <= 0 and `fifo_wr_data` holds its value.
- **Release (GRANT -> IDLE)**, in priority order:
  - `req_valid[grant_id]` is low: no beat that cycle.
  - A transfer makes `beat_cnt` reach the burst limit.
  - On release, `rr_ptr` <= `grant_id`.
- **FIFO full** (`space_ok`=0): the grant is held and ready stays low indefinitely. There is no timeout and no re-arbitration.
- Requests that arrive while in GRANT wait for the next IDLE.
- Reset at any point aborts the grant. An in-flight `fifo_wr_en` pulse is cleared, so that beat is dropped and the producer must not treat it as delivered.
- Reset values:
  - `fifo_wr_en`=0, `fifo_wr_data`=0, `grant_id`=0, `busy`=0, `req_ready`=0, state=IDLE.
  - `rr_ptr`=NUM_REQ-1, so requester 0 wins first.

## Timing
- Arbitration takes 1 cycle: IDLE to first acceptance is at least 1 clk after valid is seen.
- Accepted beat to `fifo_wr_en` high: 1 cycle.
- Peak throughput inside a grant is 1 beat/clk. Each re-arbitration costs 1 idle cycle.
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1) grants.
- `req_data` and `req_valid` must be held stable while valid is high and ready is low.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- **Defined:** the burst limit is BURST_LEN. The grantee keeps the port for up to BURST_LEN consecutive beats.
- **Undefined:** the burst limit is 1. Every grant carries exactly one beat, then the arbiter returns to IDLE (max 1 beat per 2 clk). The burst-limit check logic is removed.

## Test plan
- **Reset check:** after rst, confirm every output is 0. Req 0 and req 2 raise valid together -> req 0 is granted first, then req 2.
- **All-request fairness:** with `FIFO_ARB_BURST_EN` and BURST_LEN=4, all 4 requesters stream continuously -> grant order is 0,1,2,3,0. Each grant writes exactly 4 beats, with 1 idle cycle between grants.
- **Full stall:** `fifo_count`=63 and one accept occurs -> ready drops the next cycle. Hold `fifo_count`=64 for 10 clk -> no `fifo_wr_en`, grant held. `fifo_count`=63 with no in-flight write -> ready returns.
- **Early release:** the grantee drops valid after 2 of 4 beats -> return to IDLE. The next valid requester is granted 1 clk later.
- **Data path:** req 1 sends 0xA5 then 0x3C -> `fifo_wr_en` high for 2 clk, with `fifo_wr_data`=0xA5 then 0x3C, each one cycle after acceptance.
- **Mid-burst reset:** assert rst during a burst -> `fifo_wr_en`=0 immediately. After reset, requester 0 wins first; without the macro, every grant is 1 beat.
